// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths, the
// hardwired-zero index, address/data typedefs and a packed-bus address helper.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REG_ZERO       = 0;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Widest packed address bus the helper below accepts (up to 8 ports).
  localparam int MAX_PORTS      = 8;
  localparam int ADDR_BUS_MAX   = MAX_PORTS * DEF_ADDR_WIDTH;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Extract the address of port i from a packed address bus (zero-extended).
  function automatic reg_addr_t unpack_addr(input logic [ADDR_BUS_MAX-1:0] bus,
                                            input int                      i);
    return bus[i*DEF_ADDR_WIDTH +: DEF_ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register. A reserve sets the bit,
// a write clears it, and a reserve wins over a same-cycle write to the same
// register (the newer producer is still in flight). Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_WR      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic                        rsv_en,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr,
  output logic [(2**ADDR_WIDTH)-1:0]  busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] r_busy;

  // Decode write ports into a clear mask and the reserve into a set mask.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int i = 0; i < NR_WR; i++) begin
      if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_ADDR))
        w_clr[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    end
    if (rsv_en && (rsv_addr != ZERO_ADDR))
      w_set[rsv_addr] = 1'b1;
  end

  // Busy state: set beats clear; bit 0 is never set so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy <= '0;
    else
      r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-pending scoreboard.
// x0 reads as zero; highest-numbered write port wins on address conflicts.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_RD      = 2,
  parameter int NR_WR      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
  input  logic                        rsv_en,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr,
  input  logic                        ren,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]            rbusy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      w_busy;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_WR      (NR_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (w_busy)
  );

  // Data array: ports applied in ascending order so the highest port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_rf[k] <= '0;
    end else begin
      for (int i = 0; i < NR_WR; i++) begin
        if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_ADDR))
          r_rf[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_rd;
      logic                  w_rb;

      assign w_ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Read mux: stored value, optional forwarding, then x0 / ren gating.
      always_comb begin
        w_rd = r_rf[w_ra];
        w_rb = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        // Forward the retiring value; only a same-cycle reserve keeps it busy.
        // Nothing is forwarded while reset is asserted since it won't land.
        for (int i = 0; i < NR_WR; i++) begin
          if (rst_n && wen[i] && (w_ra != ZERO_ADDR) &&
              (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)) begin
            w_rd = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_rb = rsv_en && (rsv_addr == w_ra);
          end
        end
`endif
        if (!ren || (w_ra == ZERO_ADDR))
          w_rd = '0;
        if (!ren)
          w_rb = 1'b0;
      end

      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
      assign rbusy[gi]                          = w_rb;
    end
  endgenerate

  // Debug accessor for the difftest harness: raw stored value of a register.
  function automatic logic [DATA_WIDTH-1:0] get_reg(input int addr);
    return r_rf[addr[ADDR_WIDTH-1:0]];
  endfunction

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued as each read is set
// up and popped/compared once the combinational outputs have settled.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             ren;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_RD      (NR),
    .NR_WR      (NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ren      (ren),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy)
  );

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen    = '0;
    rsv_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p]           = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic exp_rd(input string tag, input int p, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic b);
    exp_t e;
    raddr[p*AW +: AW] = a;
    e.tag  = tag;
    e.port = p;
    e.data = d;
    e.busy = b;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t      e;
    reg_addr_t a;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = unpack_addr(ADDR_BUS_MAX'(raddr), e.port);
      checks++;
      assert (rdata[e.port*DW +: DW] === e.data) else begin
        failures++;
        $error("FAIL %s rdata port%0d x%0d: got %h want %h",
               e.tag, e.port, a, rdata[e.port*DW +: DW], e.data);
      end
      checks++;
      assert (rbusy[e.port] === e.busy) else begin
        failures++;
        $error("FAIL %s rbusy port%0d x%0d: got %b want %b",
               e.tag, e.port, a, rbusy[e.port], e.busy);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    ren      = 1'b0;
    raddr    = '0;
    repeat (2) step();

    // 1. Writes and reserves while reset is held must all be ignored.
    ren = 1'b1;
    for (int a = 1; a < 32; a += 2) begin
      set_wr(0, AW'(a), '1);
      set_wr(1, AW'(a + 1), '1);
      rsv_en   = 1'b1;
      rsv_addr = AW'(a);
      exp_rd("rst_hold", 0, AW'(a), '0, 1'b0);
      check_outputs();
      step();
    end
    idle();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a += 2) begin
      exp_rd("rst_val", 0, AW'(a), '0, 1'b0);
      exp_rd("rst_val", 1, AW'(a + 1), '0, 1'b0);
      check_outputs();
    end

    // 2. Basic write, x0 write dropped, ren gating.
    step();
    set_wr(0, AW'(5), 32'h0000_1234);
    set_wr(1, AW'(0), 32'h0000_DEAD);
    step();
    idle();
    exp_rd("basic", 0, AW'(5), 32'h0000_1234, 1'b0);
    exp_rd("x0_zero", 1, AW'(0), '0, 1'b0);
    check_outputs();
    ren = 1'b0;
    exp_rd("ren_off", 0, AW'(5), '0, 1'b0);
    check_outputs();
    ren = 1'b1;

    // 3. Same-address write conflict: port 1 wins.
    step();
    set_wr(0, AW'(7), 32'h0000_AAAA);
    set_wr(1, AW'(7), 32'h0000_BBBB);
    step();
    idle();
    exp_rd("conflict", 0, AW'(7), 32'h0000_BBBB, 1'b0);
    check_outputs();

    // 4. Scoreboard: reserve, clear by write, reserve beats write.
    rsv_en   = 1'b1;
    rsv_addr = AW'(9);
    step();
    idle();
    exp_rd("rsv_busy", 0, AW'(9), '0, 1'b1);
    check_outputs();
    set_wr(0, AW'(9), 32'h0000_0099);
`ifdef REGFILE_BYPASS_EN
    exp_rd("wr_clr_pre", 0, AW'(9), 32'h0000_0099, 1'b0);
`else
    exp_rd("wr_clr_pre", 0, AW'(9), '0, 1'b1);
`endif
    check_outputs();
    step();
    idle();
    exp_rd("wr_clr", 0, AW'(9), 32'h0000_0099, 1'b0);
    check_outputs();
    rsv_en   = 1'b1;
    rsv_addr = AW'(9);
    set_wr(1, AW'(9), 32'h0000_0077);
`ifdef REGFILE_BYPASS_EN
    exp_rd("rsv_wr_pre", 1, AW'(9), 32'h0000_0077, 1'b1);
`else
    exp_rd("rsv_wr_pre", 1, AW'(9), 32'h0000_0099, 1'b0);
`endif
    check_outputs();
    step();
    idle();
    exp_rd("rsv_wr", 1, AW'(9), 32'h0000_0077, 1'b1);
    check_outputs();
    rsv_en   = 1'b1;
    rsv_addr = AW'(0);
    step();
    idle();
    exp_rd("rsv_x0", 0, AW'(0), '0, 1'b0);
    check_outputs();

    // 5. Same-cycle read of a register being written.
    set_wr(0, AW'(3), 32'h0000_0055);
`ifdef REGFILE_BYPASS_EN
    exp_rd("byp_same", 0, AW'(3), 32'h0000_0055, 1'b0);
`else
    exp_rd("byp_same", 0, AW'(3), '0, 1'b0);
`endif
    check_outputs();
    step();
    idle();
    exp_rd("byp_next", 0, AW'(3), 32'h0000_0055, 1'b0);
    check_outputs();
    set_wr(0, AW'(3), 32'h0000_0001);
    set_wr(1, AW'(3), 32'h0000_0002);
`ifdef REGFILE_BYPASS_EN
    exp_rd("byp_prio", 1, AW'(3), 32'h0000_0002, 1'b0);
`else
    exp_rd("byp_prio", 1, AW'(3), 32'h0000_0055, 1'b0);
`endif
    check_outputs();
    step();
    idle();
    exp_rd("prio_next", 1, AW'(3), 32'h0000_0002, 1'b0);
    check_outputs();

    // 6. Asynchronous reset between edges with a write pending.
    set_wr(0, AW'(12), 32'h0000_0ABC);
    step();
    idle();
    exp_rd("pre_arst", 0, AW'(12), 32'h0000_0ABC, 1'b0);
    check_outputs();
    set_wr(0, AW'(12), 32'h0000_0FFF);
#1;
    rst_n = 1'b0;
    exp_rd("arst_now", 0, AW'(12), '0, 1'b0);
    exp_rd("arst_busy", 1, AW'(9), '0, 1'b0);
    check_outputs();
    step();
    idle();
    rst_n = 1'b1;
    exp_rd("arst_lost", 0, AW'(12), '0, 1'b0);
    exp_rd("arst_x9", 1, AW'(9), '0, 1'b0);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
